imem_dmem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between instruction fetch (I) and load/store (D).
// - Sits between the fetch stage/PC, the LSU (load/store unit) and the memory macro.
// - Allows one outstanding transaction at a time; each response is routed to the port that issued it.
// - Default priority is D over I; a starvation counter guarantees that fetch makes progress.

---
 rtl/riscv_mem_pkg.sv | 9 +
 rtl/imem_dmem_port_arbiter.sv | 105 ++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared memory-port constants for the I/D arbiter
package riscv_mem_pkg;
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_WAIT = 1'b1;
    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam int         AW_DEF   = 32;
    localparam int         DW_DEF   = 32;
endpackage

// File: rtl/imem_dmem_port_arbiter.sv
// rtl/imem_dmem_port_arbiter.sv - fetch/LSU arbiter for one single-ported memory
// D-over-I priority with a starvation counter; one outstanding transaction at a time.
module imem_dmem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy,
    output logic            err_spurious
);
    localparam int            CW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [0:0]    r_state;
    logic          r_owner;
    logic          r_store;
    logic          r_err;
    logic [CW-1:0] r_starve;

    logic w_idle;
    logic w_force_i;
    logic w_i_win;
    logic w_d_win;
    logic w_rsp;

    assign w_idle    = (r_state == ARB_IDLE);
    assign w_force_i = (STARVE_LIMIT != 0) && (r_starve == LIM);
    assign w_i_win   = w_idle && i_req && (!d_req || w_force_i);
    assign w_d_win   = w_idle && d_req && !w_i_win;
    assign w_rsp     = !w_idle && m_rvalid;

    assign m_req   = w_idle && (i_req || d_req);
    assign m_we    = w_d_win && d_we;
    assign m_be    = w_d_win ? d_be : '0;
    assign m_addr  = w_d_win ? d_addr : (w_i_win ? i_addr : '0);
    assign m_wdata = w_d_win ? d_wdata : '0;

    assign i_gnt = w_i_win && m_gnt;
    assign d_gnt = w_d_win && m_gnt;

    assign i_rvalid = w_rsp && (r_owner == OWN_I);
    assign d_rvalid = w_rsp && (r_owner == OWN_D);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    // A store acknowledge carries no data, so whatever is on m_rdata is dropped.
    assign d_rdata  = (d_rvalid && !r_store) ? m_rdata : '0;

    assign busy         = !w_idle;
    assign err_spurious = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_owner  <= OWN_I;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
            r_starve <= '0;
        end else begin
            if (w_idle) begin
                if (m_rvalid) begin
                    r_err <= 1'b1;
                end
                if (i_gnt) begin
                    r_state  <= ARB_WAIT;
                    r_owner  <= OWN_I;
                    r_store  <= 1'b0;
                    r_starve <= '0;
                end else if (d_gnt) begin
                    r_state <= ARB_WAIT;
                    r_owner <= OWN_D;
                    r_store <= d_we;
                    if (i_req && (r_starve != LIM)) begin
                        r_starve <= r_starve + CW'(1);
                    end
                end
            end else if (m_rvalid) begin
                r_state <= ARB_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb/tb_imem_dmem_port_arbiter.sv - self-checking bench for imem_dmem_port_arbiter
module tb_imem_dmem_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        busy, err_spurious;

    imem_dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an outstanding-slot, a lost-arbitration tally, a sticky flag.
    int          md_pend, md_lost;
    bit          md_own_d, md_store, md_err;
    logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_m_req, e_m_we, e_busy, e_err;
    logic [31:0] e_i_rd, e_d_rd, e_m_addr, e_m_wd;
    logic [3:0]  e_m_be;
    bit          check_model = 0;

    task automatic model_reset();
        md_pend = 0; md_lost = 0; md_own_d = 0; md_store = 0; md_err = 0;
    endtask

    task automatic model_eval();
        bit iw, dw;
        {e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_m_req, e_m_we, e_busy} = '0;
        {e_i_rd, e_d_rd, e_m_addr, e_m_wd} = '0;
        e_m_be = '0;
        e_err  = md_err;
        if (md_pend == 0) begin
            if (i_req && d_req) iw = (LIMIT != 0) && (md_lost >= LIMIT);
            else                iw = i_req;
            dw       = d_req && !iw;
            e_m_req  = i_req || d_req;
            e_m_addr = dw ? d_addr : (iw ? i_addr : 32'h0);
            e_m_we   = dw && d_we;
            e_m_be   = dw ? d_be : 4'h0;
            e_m_wd   = dw ? d_wdata : 32'h0;
            e_i_gnt  = iw && m_gnt;
            e_d_gnt  = dw && m_gnt;
        end else begin
            e_busy = 1'b1;
            if (m_rvalid) begin
                if (md_own_d) begin
                    e_d_rv = 1'b1;
                    e_d_rd = md_store ? 32'h0 : m_rdata;
                end else begin
                    e_i_rv = 1'b1;
                    e_i_rd = m_rdata;
                end
            end
        end
    endtask

    task automatic model_commit();
        if (md_pend == 0) begin
            if (m_rvalid) md_err = 1;
            if (e_i_gnt) begin
                md_pend = 1; md_own_d = 0; md_store = 0; md_lost = 0;
            end else if (e_d_gnt) begin
                md_pend = 1; md_own_d = 1; md_store = d_we;
                if (i_req && md_lost < LIMIT) md_lost++;
            end
        end else if (m_rvalid) begin
            md_pend = 0;
        end
    endtask

    task automatic model_compare();
        chk("m_i_gnt", 32'(i_gnt), 32'(e_i_gnt));
        chk("m_d_gnt", 32'(d_gnt), 32'(e_d_gnt));
        chk("m_i_rvalid", 32'(i_rvalid), 32'(e_i_rv));
        chk("m_i_rdata", i_rdata, e_i_rd);
        chk("m_d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
        chk("m_d_rdata", d_rdata, e_d_rd);
        chk("m_m_req", 32'(m_req), 32'(e_m_req));
        chk("m_m_we", 32'(m_we), 32'(e_m_we));
        chk("m_m_be", 32'(m_be), 32'(e_m_be));
        chk("m_m_addr", m_addr, e_m_addr);
        chk("m_m_wdata", m_wdata, e_m_wd);
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_err", 32'(err_spurious), 32'(e_err));
    endtask

    // Caller drives inputs just after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        if (check_model) model_compare();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset(input bit check);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        if (check) begin
            chk("rst_i_gnt", 32'(i_gnt), 0);
            chk("rst_d_gnt", 32'(d_gnt), 0);
            chk("rst_m_req", 32'(m_req), 0);
            chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);
            chk("rst_rdata", i_rdata | d_rdata, 0);
            chk("rst_m_bus", m_addr | m_wdata | 32'(m_be) | 32'(m_we), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err_spurious), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        ir; logic [31:0] ia;
        logic        dr; logic dwe; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
        logic        mg; logic mrv; logic [31:0] mrd;
        logic        x_igt, x_dgt, x_irv; logic [31:0] x_ird;
        logic        x_drv; logic [31:0] x_drd;
        logic        x_mreq, x_mwe; logic [3:0] x_mbe; logic [31:0] x_maddr, x_mwd;
        logic        x_busy;
    } vec_t;

    function automatic vec_t mk(
        logic ir, logic [31:0] ia, logic dr, logic dwe, logic [3:0] dbe, logic [31:0] da,
        logic [31:0] dwd, logic mg, logic mrv, logic [31:0] mrd,
        logic igt, logic dgt, logic irv, logic [31:0] ird, logic drv, logic [31:0] drd,
        logic mreq, logic mwe, logic [3:0] mbe, logic [31:0] maddr, logic [31:0] mwd, logic bsy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.mg = mg; v.mrv = mrv; v.mrd = mrd;
        v.x_igt = igt; v.x_dgt = dgt; v.x_irv = irv; v.x_ird = ird; v.x_drv = drv; v.x_drd = drd;
        v.x_mreq = mreq; v.x_mwe = mwe; v.x_mbe = mbe; v.x_maddr = maddr; v.x_mwd = mwd;
        v.x_busy = bsy;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        idle_inputs();

        //           ir ia     dr we be    da      dwd           mg mrv mrd
        //           igt dgt irv ird          drv drd           mreq mwe mbe maddr   mwd           busy
        vecs.push_back(mk(1, 32'h10, 0,0,4'h0, 32'h0,   32'h0,        1,0, 32'h0,
                          1,0,0, 32'h0,        0, 32'h0,        1,0,4'h0, 32'h10,  32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0,0,4'h0, 32'h0,   32'h0,        0,1, 32'h00500093,
                          0,0,1, 32'h00500093, 0, 32'h0,        0,0,4'h0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(0, 32'h0,  0,0,4'h0, 32'h0,   32'h0,        0,0, 32'h0,
                          0,0,0, 32'h0,        0, 32'h0,        0,0,4'h0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  1,1,4'h3, 32'h200, 32'hDEADBEEF, 1,0, 32'h0,
                          0,1,0, 32'h0,        0, 32'h0,        1,1,4'h3, 32'h200, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 32'h0,  0,0,4'h0, 32'h0,   32'h0,        0,1, 32'h12345678,
                          0,0,0, 32'h0,        1, 32'h0,        0,0,4'h0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(1, 32'h20, 1,0,4'hF, 32'h100, 32'h0,        1,0, 32'h0,
                          0,1,0, 32'h0,        0, 32'h0,        1,0,4'hF, 32'h100, 32'h0,        0));
        vecs.push_back(mk(1, 32'h20, 0,0,4'h0, 32'h0,   32'h0,        1,1, 32'hAAAA5555,
                          0,0,0, 32'h0,        1, 32'hAAAA5555, 0,0,4'h0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(1, 32'h20, 0,0,4'h0, 32'h0,   32'h0,        1,0, 32'h0,
                          1,0,0, 32'h0,        0, 32'h0,        1,0,4'h0, 32'h20,  32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0,0,4'h0, 32'h0,   32'h0,        0,1, 32'h11,
                          0,0,1, 32'h11,       0, 32'h0,        0,0,4'h0, 32'h0,   32'h0,        1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 32'h30, 0,0,4'h0, 32'h0, 32'h0,      0,0, 32'h0,
                              0,0,0, 32'h0,      0, 32'h0,      1,0,4'h0, 32'h30,  32'h0,        0));
        vecs.push_back(mk(1, 32'h30, 0,0,4'h0, 32'h0,   32'h0,        1,0, 32'h0,
                          1,0,0, 32'h0,        0, 32'h0,        1,0,4'h0, 32'h30,  32'h0,        0));
        vecs.push_back(mk(0, 32'h0,  0,0,4'h0, 32'h0,   32'h0,        0,1, 32'h22,
                          0,0,1, 32'h22,       0, 32'h0,        0,0,4'h0, 32'h0,   32'h0,        1));

        do_reset(1);

        foreach (vecs[n]) begin
            i_req = vecs[n].ir; i_addr = vecs[n].ia;
            d_req = vecs[n].dr; d_we = vecs[n].dwe; d_be = vecs[n].dbe;
            d_addr = vecs[n].da; d_wdata = vecs[n].dwd;
            m_gnt = vecs[n].mg; m_rvalid = vecs[n].mrv; m_rdata = vecs[n].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_i_gnt", n), 32'(i_gnt), 32'(vecs[n].x_igt));
            chk($sformatf("v%0d_d_gnt", n), 32'(d_gnt), 32'(vecs[n].x_dgt));
            chk($sformatf("v%0d_i_rvalid", n), 32'(i_rvalid), 32'(vecs[n].x_irv));
            chk($sformatf("v%0d_i_rdata", n), i_rdata, vecs[n].x_ird);
            chk($sformatf("v%0d_d_rvalid", n), 32'(d_rvalid), 32'(vecs[n].x_drv));
            chk($sformatf("v%0d_d_rdata", n), d_rdata, vecs[n].x_drd);
            chk($sformatf("v%0d_m_req", n), 32'(m_req), 32'(vecs[n].x_mreq));
            chk($sformatf("v%0d_m_we", n), 32'(m_we), 32'(vecs[n].x_mwe));
            chk($sformatf("v%0d_m_be", n), 32'(m_be), 32'(vecs[n].x_mbe));
            chk($sformatf("v%0d_m_addr", n), m_addr, vecs[n].x_maddr);
            chk($sformatf("v%0d_m_wdata", n), m_wdata, vecs[n].x_mwd);
            chk($sformatf("v%0d_busy", n), 32'(busy), 32'(vecs[n].x_busy));
            @(posedge clk);
            #1;
        end

        // Starvation: both held; grants alternate with responses.
        do_reset(0);
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400;
        for (int g = 0; g < 10; g++) begin
            bit exp_i;
            exp_i = (g == 4) || (g == 9);
            m_gnt = 1; m_rvalid = 0;
            @(negedge clk);
            chk($sformatf("starve%0d_i_gnt", g), 32'(i_gnt), 32'(exp_i));
            chk($sformatf("starve%0d_d_gnt", g), 32'(d_gnt), 32'(!exp_i));
            chk($sformatf("starve%0d_m_addr", g), m_addr, exp_i ? 32'h40 : 32'h400);
            if (exp_i) chk($sformatf("starve%0d_m_be", g), 32'({m_we, m_be}), 0);
            @(posedge clk); #1;
            m_rvalid = 1; m_rdata = 32'(g);
            @(negedge clk);
            chk($sformatf("starve%0d_rsp_i", g), 32'(i_rvalid), 32'(exp_i));
            chk($sformatf("starve%0d_rsp_d", g), 32'(d_rvalid), 32'(!exp_i));
            chk($sformatf("starve%0d_no_gnt", g), 32'({i_gnt, d_gnt, m_req}), 0);
            @(posedge clk); #1;
        end

        // Reset while WAIT, then a late response.
        do_reset(0);
        i_req = 1; i_addr = 32'h50; m_gnt = 1;
        step();
        idle_inputs();
        chk("rstwait_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        step();
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstwait_i_rvalid", 32'(i_rvalid), 0);
        chk("rstwait_d_rvalid", 32'(d_rvalid), 0);
        chk("rstwait_busy", 32'(busy), 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rstwait_err", 32'(err_spurious), 1);
        chk("rstwait_idle", 32'(busy), 0);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        do_reset(0);
        check_model = 1;
        for (int c = 0; c < 3000; c++) begin
            i_req    = ($urandom_range(0, 3) != 0);
            i_addr   = $urandom & 32'hFFFF_FFFC;
            d_req    = ($urandom_range(0, 2) != 0);
            d_we     = $urandom_range(0, 1) != 0;
            d_be     = 4'($urandom);
            d_addr   = $urandom;
            d_wdata  = $urandom;
            m_gnt    = ($urandom_range(0, 3) != 0);
            m_rvalid = (md_pend != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
            m_rdata  = $urandom;
            step();
        end
        check_model = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
